// File: rtl/bitscan_pkg.sv
// Shared types for the set-bit iterator: FSM state encoding.
package bitscan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } iter_state_e;

endpackage

// File: rtl/lsb_index.sv
// Combinational lowest-set-bit locator: index of the least significant 1 and a zero flag.
module lsb_index #(
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned IDX_W      = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] word,
  output logic [IDX_W-1:0]      idx,
  output logic                  none
);

  // Scan from the top down so the lowest set bit is the last to write idx.
  always_comb begin
    idx  = '0;
    none = (word == '0);
    for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
      if (word[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/set_bit_iter.sv
// Serialises each accepted word into a stream of set-bit indices, lowest first,
// with the final beat flagged; an all-zero word yields a single zero-flagged beat.
module set_bit_iter
  import bitscan_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned IDX_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [IDX_W-1:0]      dout,
  output logic                  dout_zero,
  output logic                  dout_last,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  iter_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  zero_q, zero_d;

  logic [DATA_WIDTH-1:0] word_rest_c;
  logic [IDX_W-1:0]      lsb_idx_c;
  logic                  lsb_none_c;
  logic                  busy_c;
  logic                  last_c;
  logic                  out_fire_c;
  logic                  in_fire_c;

  lsb_index #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lsb_index (
    .word (word_q),
    .idx  (lsb_idx_c),
    .none (lsb_none_c)
  );

  // Beat decode and handshakes; a last beat frees the slot in the same cycle.
  always_comb begin
    busy_c      = (state_q == BUSY);
    word_rest_c = word_q & (word_q - DATA_WIDTH'(1));
    last_c      = zero_q | lsb_none_c | (word_rest_c == '0);
    out_fire_c  = busy_c & dout_ready;
    din_ready   = ~busy_c | (out_fire_c & last_c);
    in_fire_c   = din_valid & din_ready;

    dout_valid  = busy_c;
    dout        = busy_c ? lsb_idx_c : '0;
    dout_zero   = busy_c & zero_q;
    dout_last   = busy_c & last_c;
  end

  // Next state: retire the lowest bit per beat, reload on accept.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    zero_d  = zero_q;

    if (out_fire_c) begin
      if (last_c) begin
        state_d = IDLE;
      end else begin
        word_d = word_rest_c;
      end
    end

    if (in_fire_c) begin
      state_d = BUSY;
      word_d  = din;
      zero_d  = (din == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      word_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: doc/set_bit_iter.md
# set_bit_iter

Serialises a data word into a stream of set-bit indices, lowest first, one index per output handshake. It sits directly downstream of word producers and reuses the trailing-zero / lowest-set-bit computation as its core. Typical consumers are per-bit service logic such as interrupt dispatch, grant walking and free-slot allocation. Each accepted word yields one or more output beats, and the final beat is flagged.

## Interface
- `DATA_WIDTH`, default 32: input word width; legal values are ≥ 2.
- `IDX_W`, default `$clog2(DATA_WIDTH)`: output index width; derived, never overridden.

Ports:
- `clk`  in  1  the single clock.
- `resetn`  in  1  reset, synchronous and active-low.
- `din`  in  DATA_WIDTH  word to enumerate.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  block accepts `din` this cycle.
- `dout`  out  IDX_W  bit index of the current lowest set bit.
- `dout_zero`  out  1  current beat represents an all-zero input word.
- `dout_last`  out  1  current beat is the final beat for this word.
- `dout_valid`  out  1  `dout`, `dout_zero` and `dout_last` are valid.
- `dout_ready`  in  1  consumer accepts the current beat.

## Operation
- Two states: `IDLE` and `BUSY`.
- Working register: `word_q[DATA_WIDTH-1:0]`, plus a `zero_q` flag.
- Input accept: `din_valid & din_ready`. On accept, `word_q <= din`, `zero_q <= (din == 0)`, and the state goes to `BUSY`.
- `din_ready = (state == IDLE) | (dout_valid & dout_ready & dout_last)`.
  - `din_ready` is combinational from `dout_ready`.
  - This gives back-to-back word acceptance with no bubble.
- In `BUSY`:
  - `dout_valid = 1`.
  - `dout` is the index of the lowest set bit of `word_q`, computed combinationally by the sub-module.
  - `dout_zero = zero_q`.
  - `dout_last = zero_q | ((word_q & (word_q - 1)) == 0)`.
- Output accept: `dout_valid & dout_ready`.
  - If not last: `word_q <= word_q & (word_q - 1)`, which clears the lowest set bit.
  - If last and there is no simultaneous input accept: go to `IDLE`.
  - If last with a simultaneous input accept: load the new word and stay `BUSY`.
- Zero word: produces exactly one beat with `dout_zero=1`, `dout=0`, `dout_last=1`.
- Beat count per non-zero word equals its popcount. Indices are strictly increasing within a word.
- In `IDLE`, all output fields are forced to 0.
- `din` is ignored whenever `din_ready=0`.

## Timing
- Reset values (reset asserted at a rising edge): state `IDLE`, `word_q=0`, `zero_q=0`. Outputs are therefore `dout_valid=0`, `dout=0`, `dout_zero=0`, `dout_last=0`, `din_ready=1`.
- Latency: a word accepted at edge N presents its first beat in cycle N+1.
- Throughput: one beat per cycle while `dout_ready=1`.
- Back-pressure: while `dout_valid & !dout_ready`, the outputs `dout`, `dout_zero` and `dout_last` hold stable.
  - `dout_valid` never drops without a handshake.
- Reset mid-word: the remaining bits are discarded. No further beats are emitted, and the cycle after reset shows `dout_valid=0`, `din_ready=1`.
- Single-bit word, e.g. `din=1<<k`: one beat, `dout=k`, `dout_last=1`.
- `din` with the MSB set: index `DATA_WIDTH-1` fits in `IDX_W` bits, and no overflow is possible.

## Structure
- Package `bitscan_pkg` holds the state enum typedef `iter_state_e` (`IDLE`, `BUSY`).
- Sub-module `lsb_index`, parameterised on `DATA_WIDTH`, is purely combinational:
  - Inputs: `word`.
  - Outputs: `idx[IDX_W-1:0]` (lowest set bit position) and `none` (word is zero).
- The top level contains only the FSM, the working register and the handshake logic.

## Test plan
All scenarios use `DATA_WIDTH=8`.
1. `din=8'b1010_0100` accepted at edge 0, `dout_ready=1` → beats in cycles 1–3 with `dout`=2, 5, 7; `dout_last` only on 7; `din_ready=1` in cycle 3; `dout_valid=0` in cycle 4.
2. `din=8'h00` → one beat with `dout_zero=1`, `dout=0`, `dout_last=1`, then `IDLE`.
3. `din=8'h81`, `dout_ready=0` for cycles 1–3 → `dout=0` held stable with `dout_last=0`; after release, beats 0 then 7 (last).
4. `din_valid` held high, 8'h01 followed by 8'h80, `dout_ready=1` → 8'h80 accepted at edge 1 (same cycle as last beat 0); cycle 1 `dout=0` last, cycle 2 `dout=7` last; no bubble.
5. `din=8'hFF`; after beats 0 and 1, `resetn=0` for one cycle → next cycle `dout_valid=0`, `din_ready=1`; no further beats until a new word is accepted.
6. `din=8'h80` → single beat with `dout=7`, `dout_last=1`, `dout_zero=0`.
